// File: rtl/cmp_vec_pkg.sv
// Shared types and constants for the comparator test-vector generator:
// FSM states, LFSR feedback mask and the fixed corner operand pairs.
package cmp_vec_pkg;

    localparam int unsigned VEC_W = 64;
    localparam int unsigned IDX_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_e;

    // Right-shifting Galois mask for x^64 + x^63 + x^61 + x^60 + 1
    localparam logic [VEC_W-1:0] LFSR_POLY = 64'hD800_0000_0000_0000;

    typedef struct packed {
        logic [VEC_W-1:0] op1;
        logic [VEC_W-1:0] op2;
    } vec_pair_t;

    localparam vec_pair_t CORNER_0 = '{op1: 64'h0000_0000_0000_0000, op2: 64'h0000_0000_0000_0000};
    localparam vec_pair_t CORNER_1 = '{op1: 64'h8000_0000_0000_0000, op2: 64'h7FFF_FFFF_FFFF_FFFF};
    localparam vec_pair_t CORNER_2 = '{op1: 64'hFFFF_FFFF_FFFF_FFFF, op2: 64'h0000_0000_0000_0000};
    localparam vec_pair_t CORNER_3 = '{op1: 64'h7FFF_FFFF_FFFF_FFFF, op2: 64'h8000_0000_0000_0000};

    function automatic vec_pair_t corner_pair(input logic [1:0] sel);
        vec_pair_t p;
        case (sel)
            2'd0:    p = CORNER_0;
            2'd1:    p = CORNER_1;
            2'd2:    p = CORNER_2;
            default: p = CORNER_3;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/cmp_vector_gen_if.sv
// Vector stream between the generator (master) and a comparator consumer (slave).
interface cmp_vector_gen_if;
    import cmp_vec_pkg::*;

    logic             vec_valid;
    logic             vec_ready;
    logic [VEC_W-1:0] op1;
    logic [VEC_W-1:0] op2;
    logic             eq_exp;
    logic             lt_exp;
    logic             ltu_exp;
    logic [IDX_W-1:0] vec_idx;

    modport master (
        output vec_valid, op1, op2, eq_exp, lt_exp, ltu_exp, vec_idx,
        input  vec_ready
    );

    modport slave (
        input  vec_valid, op1, op2, eq_exp, lt_exp, ltu_exp, vec_idx,
        output vec_ready
    );
endinterface

// File: rtl/cmp_vector_gen_lfsr64.sv
// 64-bit Galois LFSR with synchronous seed load and single-step advance.
module lfsr64
    import cmp_vec_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [VEC_W-1:0] seed_i,
    input  logic             load_i,
    input  logic             adv_i,
    output logic [VEC_W-1:0] state_o
);

    logic [VEC_W-1:0] state_q;
    logic [VEC_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (adv_i) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= seed_i;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/cmp_vector_gen.sv
// Streams operand pairs with expected eq/signed-lt/unsigned-lt results:
// four fixed corner vectors, then LFSR pairs with periodic forced-equal pairs.
module cmp_vector_gen
    import cmp_vec_pkg::*;
#(
    parameter int unsigned      NUM_VECTORS = 8192,
    parameter logic [VEC_W-1:0] SEED        = 64'h0123_4567_89AB_CDEF,
    parameter int unsigned      EQ_EVERY    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    cmp_vector_gen_if.master  vif
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VEC_W-1:0] op1_q, op1_d;
    logic [VEC_W-1:0] op2_q, op2_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             ltu_q, ltu_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             hs_c;
    logic             last_c;
    logic             gen_c;
    logic [IDX_W-1:0] gen_idx_c;
    logic             seed_load_c;
    logic             adv_c;
    logic             force_eq_c;
    vec_pair_t        pair_c;
    logic [VEC_W-1:0] lfsr_a_c;
    logic [VEC_W-1:0] lfsr_b_c;

    lfsr64 u_lfsr_a (
        .clk     (clk),
        .reset_n (reset_n),
        .seed_i  (SEED),
        .load_i  (seed_load_c),
        .adv_i   (adv_c),
        .state_o (lfsr_a_c)
    );

    lfsr64 u_lfsr_b (
        .clk     (clk),
        .reset_n (reset_n),
        .seed_i  (~SEED),
        .load_i  (seed_load_c),
        .adv_i   (adv_c),
        .state_o (lfsr_b_c)
    );

    assign hs_c       = (state_q == ST_SEND) && valid_q && vif.vec_ready;
    assign last_c     = (idx_q == IDX_W'(NUM_VECTORS - 1));
    assign force_eq_c = ((32'(gen_idx_c) % EQ_EVERY) == (EQ_EVERY - 1));

    // Next state plus the vector for either the loaded index or its successor
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        eq_d        = eq_q;
        lt_d        = lt_q;
        ltu_d       = ltu_q;
        gen_c       = 1'b0;
        gen_idx_c   = idx_q;
        seed_load_c = 1'b0;
        adv_c       = 1'b0;
        pair_c      = CORNER_0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    idx_d       = '0;
                    seed_load_c = 1'b1;
                end
            end
            ST_LOAD: begin
                gen_c   = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (hs_c) begin
                    if (last_c) begin
                        state_d = ST_DONE;
                    end else begin
                        gen_c     = 1'b1;
                        gen_idx_c = idx_q + IDX_W'(1);
                        idx_d     = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (gen_c) begin
            if (gen_idx_c < IDX_W'(4)) begin
                pair_c = corner_pair(gen_idx_c[1:0]);
            end else begin
                adv_c      = 1'b1;
                pair_c.op1 = lfsr_a_c;
                pair_c.op2 = force_eq_c ? lfsr_a_c : lfsr_b_c;
            end
            op1_d = pair_c.op1;
            op2_d = pair_c.op2;
            eq_d  = (pair_c.op1 == pair_c.op2);
            lt_d  = ($signed(pair_c.op1) < $signed(pair_c.op2));
            ltu_d = (pair_c.op1 < pair_c.op2);
        end

        valid_d = (state_d == ST_SEND);
        busy_d  = (state_d == ST_LOAD) || (state_d == ST_SEND);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            ltu_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            ltu_q   <= ltu_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign vif.vec_valid = valid_q;
    assign vif.op1       = op1_q;
    assign vif.op2       = op2_q;
    assign vif.eq_exp    = eq_q;
    assign vif.lt_exp    = lt_q;
    assign vif.ltu_exp   = ltu_q;
    assign vif.vec_idx   = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_cmp_vector_gen.sv
// Scoreboard bench for cmp_vector_gen: a default-size instance and a
// 16-vector / period-4 instance, each checked against a software model.
module tb_cmp_vector_gen;

    localparam logic [63:0] SEED_TB = 64'h0123_4567_89AB_CDEF;
    localparam int          N_MAIN  = 8192;

    typedef struct packed {
        logic [15:0] idx;
        logic [63:0] op1;
        logic [63:0] op2;
        logic        eq;
        logic        lt;
        logic        ltu;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic start16 = 1'b0;
    logic busy, done, busy16, done16;

    int n_total = 0;
    int n_pass  = 0;
    int hs_main = 0;
    int hs16    = 0;

    exp_t q_main[$];
    exp_t q16[$];

    cmp_vector_gen_if vif ();
    cmp_vector_gen_if vif16 ();

    cmp_vector_gen dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .vif     (vif)
    );

    cmp_vector_gen #(.NUM_VECTORS(16), .EQ_EVERY(4)) dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start16),
        .busy    (busy16),
        .done    (done16),
        .vif     (vif16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        logic [63:0] n;
        n = {1'b0, s[63:1]};
        if (s[0]) begin
            n[63] = ~n[63];
            n[62] = ~n[62];
            n[60] = ~n[60];
            n[59] = ~n[59];
        end
        return n;
    endfunction

    function automatic exp_t model_vec(input int idx, input int eqe,
                                       input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        e.idx = 16'(idx);
        case (idx)
            0: begin e.op1 = 64'h0; e.op2 = 64'h0; e.eq = 1; e.lt = 0; e.ltu = 0; end
            1: begin e.op1 = 64'h8000_0000_0000_0000; e.op2 = 64'h7FFF_FFFF_FFFF_FFFF;
                     e.eq = 0; e.lt = 1; e.ltu = 0; end
            2: begin e.op1 = 64'hFFFF_FFFF_FFFF_FFFF; e.op2 = 64'h0;
                     e.eq = 0; e.lt = 1; e.ltu = 0; end
            3: begin e.op1 = 64'h7FFF_FFFF_FFFF_FFFF; e.op2 = 64'h8000_0000_0000_0000;
                     e.eq = 0; e.lt = 0; e.ltu = 1; end
            default: begin
                e.op1 = a;
                e.op2 = ((idx % eqe) == eqe - 1) ? a : b;
                e.eq  = (e.op1 == e.op2);
                e.lt  = ($signed(e.op1) < $signed(e.op2));
                e.ltu = (e.op1 < e.op2);
            end
        endcase
        return e;
    endfunction

    task automatic fill_main();
        logic [63:0] a, b;
        a = SEED_TB;
        b = ~SEED_TB;
        q_main.delete();
        for (int i = 0; i < N_MAIN; i++) begin
            q_main.push_back(model_vec(i, 8, a, b));
            if (i >= 4) begin
                a = lfsr_step(a);
                b = lfsr_step(b);
            end
        end
    endtask

    task automatic fill_16();
        logic [63:0] a, b;
        a = SEED_TB;
        b = ~SEED_TB;
        q16.delete();
        for (int i = 0; i < 16; i++) begin
            q16.push_back(model_vec(i, 4, a, b));
            if (i >= 4) begin
                a = lfsr_step(a);
                b = lfsr_step(b);
            end
        end
    endtask

    // Handshake monitors pop the scoreboard on every accepted vector
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && vif.vec_valid && vif.vec_ready) begin
            if (q_main.size() == 0) begin
                check("main_extra_hs", 64'(vif.vec_idx), 64'hFFFF);
            end else begin
                e = q_main.pop_front();
                check("main_idx", 64'(vif.vec_idx), 64'(e.idx));
                check("main_op1", vif.op1, e.op1);
                check("main_op2", vif.op2, e.op2);
                check("main_eq", 64'(vif.eq_exp), 64'(e.eq));
                check("main_lt", 64'(vif.lt_exp), 64'(e.lt));
                check("main_ltu", 64'(vif.ltu_exp), 64'(e.ltu));
                hs_main++;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset_n && vif16.vec_valid && vif16.vec_ready) begin
            if (q16.size() == 0) begin
                check("n16_extra_hs", 64'(vif16.vec_idx), 64'hFFFF);
            end else begin
                e = q16.pop_front();
                check("n16_idx", 64'(vif16.vec_idx), 64'(e.idx));
                check("n16_op1", vif16.op1, e.op1);
                check("n16_op2", vif16.op2, e.op2);
                check("n16_eq", 64'(vif16.eq_exp), 64'(e.eq));
                check("n16_lt", 64'(vif16.lt_exp), 64'(e.lt));
                check("n16_ltu", 64'(vif16.ltu_exp), 64'(e.ltu));
                hs16++;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_random_to_done(input string tag);
        int cyc = 0;
        while (!done && cyc < 40000) begin
            @(posedge clk); #1;
            vif.vec_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        exp_t held;
        int   cyc;
        bit   stalled;

        vif.vec_ready   = 1'b0;
        vif16.vec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Post-reset idle
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(vif.vec_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_op1", vif.op1, 64'd0);
        check("rst_op2", vif.op2, 64'd0);
        check("rst_flags", {61'd0, vif.eq_exp, vif.lt_exp, vif.ltu_exp}, 64'd0);
        check("rst_idx", 64'(vif.vec_idx), 64'd0);
        check("rst16_valid", 64'(vif16.vec_valid), 64'd0);

        // Run A: ready high, one 10-cycle stall on index 5
        fill_main();
        hs_main = 0;
        vif.vec_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        check("load_valid", 64'(vif.vec_valid), 64'd0);
        check("load_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("send_valid", 64'(vif.vec_valid), 64'd1);
        stalled = 0;
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (!stalled && vif.vec_valid && vif.vec_idx == 16'd5) begin
                vif.vec_ready = 1'b0;
                stalled = 1;
                held = q_main[0];
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    check("stall_idx", 64'(vif.vec_idx), 64'(held.idx));
                    check("stall_op1", vif.op1, held.op1);
                    check("stall_op2", vif.op2, held.op2);
                    check("stall_flags", {61'd0, vif.eq_exp, vif.lt_exp, vif.ltu_exp},
                          {61'd0, held.eq, held.lt, held.ltu});
                    check("stall_valid", 64'(vif.vec_valid), 64'd1);
                end
                @(posedge clk); #1 vif.vec_ready = 1'b1;
            end
        end
        if (!done) check("runA_timeout", 64'd0, 64'd1);
        check("runA_stalled", 64'(stalled), 64'd1);
        @(negedge clk);
        check("runA_hs", 64'(hs_main), 64'(N_MAIN));
        check("runA_valid_off", 64'(vif.vec_valid), 64'd0);
        check("runA_busy_off", 64'(busy), 64'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("done_held", 64'(done), 64'd1);

        // Run B: random ready, aborted by reset while index 9 is presented
        fill_main();
        hs_main = 0;
        pulse_start();
        cyc = 0;
        while (!(vif.vec_valid && vif.vec_idx == 16'd9) && cyc < 1000) begin
            @(posedge clk); #1;
            vif.vec_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        check("runB_reach9", 64'(vif.vec_idx), 64'd9);
        reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check("abort_valid", 64'(vif.vec_valid), 64'd0);
        check("abort_idx", 64'(vif.vec_idx), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_op1", vif.op1, 64'd0);

        // Run C: replay after abort, random ready over the full run
        fill_main();
        hs_main = 0;
        pulse_start();
        run_random_to_done("runC");
        @(negedge clk);
        check("runC_hs", 64'(hs_main), 64'(N_MAIN));
        check("runC_q_empty", 64'(q_main.size()), 64'd0);
        vif.vec_ready = 1'b0;

        // 16-vector instance, with a start pulse mid-run that must be ignored
        fill_16();
        hs16 = 0;
        vif16.vec_ready = 1'b1;
        @(posedge clk); #1 start16 = 1'b1;
        @(posedge clk); #1 start16 = 1'b0;
        cyc = 0;
        while (!done16 && cyc < 200) begin
            @(posedge clk); #1;
            start16 = (cyc == 6);
            cyc++;
        end
        start16 = 1'b0;
        if (!done16) check("n16_timeout", 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("n16_hs", 64'(hs16), 64'd16);
        check("n16_done", 64'(done16), 64'd1);
        check("n16_valid_off", 64'(vif16.vec_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
